mii_tx_arbiter: RTL

//  Shares one 64-bit/8-ctrl MII transmit lane between N_SRC frame sources (e.g. several frame generators).

---
 rtl/mii_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/mii_tx_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mii_pkg.sv
// mii_pkg: shared constants, arbiter state type and column classifiers for
// the MII transmit arbiter.
//   IDLE_C/START_C/TERM_C/ERR_C  MII control characters
//   arb_state_t                  S_IDLE / S_XFER
//   is_start(data, ctrl)         lane 0 carries a START control character
//   is_term(data, ctrl)          some lane carries a TERM control character
//                                and the column is not a start column
package mii_pkg;

  localparam logic [7:0] IDLE_C  = 8'h07;
  localparam logic [7:0] START_C = 8'hFB;
  localparam logic [7:0] TERM_C  = 8'hFD;
  localparam logic [7:0] ERR_C   = 8'hFE;

  typedef enum logic {S_IDLE, S_XFER} arb_state_t;

  function automatic logic is_start(input logic [63:0] data, input logic [7:0] ctrl,
                                    input logic [7:0] start_code = START_C);
    return ctrl[0] && (data[7:0] == start_code);
  endfunction

  function automatic logic is_term(input logic [63:0] data, input logic [7:0] ctrl,
                                   input logic [7:0] term_code = TERM_C,
                                   input logic [7:0] start_code = START_C);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ctrl[i] && (data[8*i +: 8] == term_code)) hit = 1'b1;
    end
    return hit && !is_start(data, ctrl, start_code);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or
// after ptr, wrapping N-1 -> 0.
//   req      in   N    request vector
//   ptr      in   IW   highest-priority index
//   gnt      out  N    one-hot winner, 0 when no request
//   gnt_idx  out  IW   index of the winner, 0 when no request
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    int   j;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found      = 1'b1;
        gnt[j]     = 1'b1;
        gnt_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mii_tx_arbiter.sv
// mii_tx_arbiter: shares one 64-bit/8-ctrl MII transmit lane between N_SRC
// frame sources. Whole frames are granted round-robin, never interleaved,
// and at least MIN_IPG idle columns follow every TERM column. An owner that
// stalls mid-frame gets error columns inserted in its place.
//   clk, i_rst_n   clock, async active-low reset
//   i_src_data     per-source column, source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_src_ctrl     per-source ctrl,   source k at [k*CTRL_WIDTH +: CTRL_WIDTH]
//   i_src_valid    column valid per source
//   o_src_ready    column accepted when valid & ready
//   o_tx_data/ctrl registered MII column, one cycle after acceptance
//   o_grant        one-hot frame owner, 0 when idle
//   o_busy         1 while a frame is in progress
// Build option MII_ARB_STATS_EN adds wrap-around 16-bit counters
//   o_frame_cnt, o_underrun_cnt, o_proto_err_cnt.
module mii_tx_arbiter
  import mii_pkg::*;
#(
  parameter int         N_SRC      = 4,
  parameter int         DATA_WIDTH = 64,
  parameter int         CTRL_WIDTH = 8,
  parameter int         MIN_IPG    = 2,
  parameter logic [7:0] IDLE_CODE  = IDLE_C,
  parameter logic [7:0] START_CODE = START_C,
  parameter logic [7:0] TERM_CODE  = TERM_C,
  parameter logic [7:0] ERR_CODE   = ERR_C
) (
  input  logic                        clk,
  input  logic                        i_rst_n,
  input  logic [N_SRC*DATA_WIDTH-1:0] i_src_data,
  input  logic [N_SRC*CTRL_WIDTH-1:0] i_src_ctrl,
  input  logic [N_SRC-1:0]            i_src_valid,
  output logic [N_SRC-1:0]            o_src_ready,
  output logic [DATA_WIDTH-1:0]       o_tx_data,
  output logic [CTRL_WIDTH-1:0]       o_tx_ctrl,
  output logic [N_SRC-1:0]            o_grant,
  output logic                        o_busy
`ifdef MII_ARB_STATS_EN
  ,
  output logic [15:0]                 o_frame_cnt,
  output logic [15:0]                 o_underrun_cnt,
  output logic [15:0]                 o_proto_err_cnt
`endif
);

  localparam int         IW      = $clog2(N_SRC);
  localparam logic [3:0] IPG_MAX = 4'(MIN_IPG);

  arb_state_t            state, state_n;
  logic [N_SRC-1:0]      grant, grant_n, arb_req, arb_gnt;
  logic [IW-1:0]         ptr, ptr_n, own_idx, own_idx_n, arb_idx, sel_idx;
  logic [3:0]            ipg_cnt, ipg_n;
  logic                  ipg_ok, arb_any;
  logic [DATA_WIDTH-1:0] sel_data, data_n;
  logic [CTRL_WIDTH-1:0] sel_ctrl, ctrl_n;
  logic                  sel_valid, sel_start, sel_term;

  assign ipg_ok  = (ipg_cnt == IPG_MAX);
  // Arbitration only runs while idle with the gap satisfied, so arb_gnt
  // doubles as the idle-state ready vector.
  assign arb_req = (state == S_IDLE && ipg_ok) ? i_src_valid : '0;
  assign arb_any = |arb_req;

  rr_arbiter #(.N(N_SRC), .IW(IW)) u_rr (
    .req     (arb_req),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign sel_idx   = (state == S_XFER) ? own_idx : arb_idx;
  assign sel_data  = i_src_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_ctrl  = i_src_ctrl[sel_idx*CTRL_WIDTH +: CTRL_WIDTH];
  assign sel_valid = i_src_valid[sel_idx];
  assign sel_start = is_start(sel_data, sel_ctrl, START_CODE);
  assign sel_term  = is_term(sel_data, sel_ctrl, TERM_CODE, START_CODE);

  assign o_src_ready = (state == S_XFER) ? grant : arb_gnt;
  assign o_grant     = grant;
  assign o_busy      = (state == S_XFER);

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    own_idx_n = own_idx;
    ptr_n     = ptr;
    ipg_n     = ipg_cnt;
    data_n    = {(DATA_WIDTH/8){IDLE_CODE}};
    ctrl_n    = '1;
    case (state)
      S_IDLE: begin
        if (!ipg_ok) ipg_n = ipg_cnt + 4'd1;
        // A non-start winner is consumed and dropped: output stays idle.
        if (arb_any && sel_start) begin
          data_n    = sel_data;
          ctrl_n    = sel_ctrl;
          grant_n   = arb_gnt;
          own_idx_n = arb_idx;
          ptr_n     = (arb_idx == IW'(N_SRC-1)) ? '0 : arb_idx + 1'b1;
          state_n   = S_XFER;
        end
      end
      S_XFER: begin
        if (sel_valid) begin
          data_n = sel_data;
          ctrl_n = sel_ctrl;
          if (sel_term) begin
            grant_n = '0;
            ipg_n   = '0;
            state_n = S_IDLE;
          end
        end else begin
          data_n = {(DATA_WIDTH/8){ERR_CODE}};
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      grant     <= '0;
      own_idx   <= '0;
      ptr       <= '0;
      ipg_cnt   <= IPG_MAX;
      o_tx_data <= {(DATA_WIDTH/8){IDLE_CODE}};
      o_tx_ctrl <= '1;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      own_idx   <= own_idx_n;
      ptr       <= ptr_n;
      ipg_cnt   <= ipg_n;
      o_tx_data <= data_n;
      o_tx_ctrl <= ctrl_n;
    end
  end

`ifdef MII_ARB_STATS_EN
  logic frame_inc, underrun_inc, proto_inc;

  assign frame_inc    = (state == S_XFER) && sel_valid && sel_term;
  assign underrun_inc = (state == S_XFER) && !sel_valid;
  assign proto_inc    = (state == S_IDLE) && arb_any && !sel_start;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_cnt     <= '0;
      o_underrun_cnt  <= '0;
      o_proto_err_cnt <= '0;
    end else begin
      if (frame_inc)    o_frame_cnt     <= o_frame_cnt + 16'd1;
      if (underrun_inc) o_underrun_cnt  <= o_underrun_cnt + 16'd1;
      if (proto_inc)    o_proto_err_cnt <= o_proto_err_cnt + 16'd1;
    end
  end
`endif

endmodule
